// File: rtl/rng_sched_pkg.sv
// Shared state encoding and helpers for the RNG epoch scheduler.
package rng_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLR   = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // RNG register plus output buffer register
  localparam int LAT_DEFAULT = 2;

  // A configured length of zero stands for the full 2^rwid sequence.
  function automatic int unsigned eff_len(input int unsigned cfg_len, input int unsigned rwid);
    return (cfg_len == 0) ? (32'd1 << rwid) : cfg_len;
  endfunction

endpackage

// File: rtl/rng_epoch_scheduler_if.sv
// Request/grant and RNG-array control bundle between the layer controllers and the scheduler.
interface rng_epoch_scheduler_if #(
  parameter int NREQ = 4,
  parameter int RWID = 8
);
  logic [NREQ-1:0] req;
  logic [RWID:0]   cfgLen;
  logic            rngClr;
  logic            rngEn;
  logic [NREQ-1:0] gnt;
  logic            streamValid;
  logic [NREQ-1:0] done;
  logic            busy;

  // master: requester side; slave: the scheduler
  modport master (
    output req, cfgLen,
    input  rngClr, rngEn, gnt, streamValid, done, busy
  );

  modport slave (
    input  req, cfgLen,
    output rngClr, rngEn, gnt, streamValid, done, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] win_onehot,
  output logic [PW-1:0]   win_idx,
  output logic            win_any
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found           = 1'b1;
        win_idx         = idx;
        win_onehot[idx] = 1'b1;
      end
    end
  end

  assign win_any = |req;

endmodule

// File: rtl/rng_epoch_scheduler.sv
// Time-shares one Sobol RNG array: per grant, clear the RNG, step it len cycles, drain the pipe, pulse done.
module rng_epoch_scheduler
  import rng_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int RWID = 8,
  parameter int LAT  = LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  rng_epoch_scheduler_if.slave  bus
);

  localparam int PW = $clog2(NREQ);
  localparam int LW = $clog2(LAT + 1);
  localparam logic [RWID:0] LEN_ONE = 1;
  localparam logic [LW-1:0] LAT_ONE = 1;

  state_t          state_reg;
  logic [RWID:0]   len_cnt_reg;
  logic [LW-1:0]   lat_cnt_reg;
  logic [PW-1:0]   rr_ptr_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [LAT-1:0]  valid_sr_reg;

  logic [NREQ-1:0] win_onehot;
  logic [PW-1:0]   win_idx;
  logic            win_any;
  logic [PW-1:0]   rr_ptr_next;
  logic            rng_en;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req        (bus.req),
    .rr_ptr     (rr_ptr_reg),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

  assign rr_ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
  assign rng_en      = (state_reg == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      len_cnt_reg <= '0;
      lat_cnt_reg <= '0;
      rr_ptr_reg  <= '0;
      gnt_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (win_any) begin
            gnt_reg     <= win_onehot;
            rr_ptr_reg  <= rr_ptr_next;
            len_cnt_reg <= (RWID + 1)'(eff_len(32'(bus.cfgLen), 32'(RWID)));
            state_reg   <= ST_CLR;
          end
        end
        ST_CLR: state_reg <= ST_RUN;
        ST_RUN: begin
          len_cnt_reg <= len_cnt_reg - LEN_ONE;
          if (len_cnt_reg == LEN_ONE) begin
            lat_cnt_reg <= LW'(LAT);
            state_reg   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          lat_cnt_reg <= lat_cnt_reg - LAT_ONE;
          if (lat_cnt_reg == LAT_ONE) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Valid tracks rngEn through the same LAT-stage delay as the array's data path.
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_valid_sr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_sr_reg[gi] <= 1'b0;
        end else begin
          valid_sr_reg[gi] <= (gi == 0) ? rng_en : valid_sr_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign bus.rngClr      = (state_reg == ST_CLR);
  assign bus.rngEn       = rng_en;
  assign bus.gnt         = gnt_reg;
  assign bus.streamValid = valid_sr_reg[LAT-1];
  assign bus.done        = (state_reg == ST_DONE) ? gnt_reg : '0;
  assign bus.busy        = (state_reg != ST_IDLE);

endmodule

// File: doc/rng_epoch_scheduler.md
Name: rng_epoch_scheduler

Overview:
Time-shares one Sobol RNG share array between NREQ stochastic-computing consumers (e.g. uBrain layer engines).
- Each granted requester gets one "epoch": the RNG is cleared to sequence index 0 and then stepped for a configured stream length.
- Outputs are the array's enable/clear controls plus per-requester grant, valid and done.
- Sits between the layer controllers and the RNG share array.

Parameters:
NREQ, 4, number of requesters (≥2)
RWID, 8, RNG width; maximum stream length is 2^RWID
LAT, 2, cycles from rngEn high to the corresponding value at the array's rngSeq outputs (RNG register + buffer register)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
req  input  NREQ  level request per requester; held until that requester's done
cfgLen  input  RWID+1  stream length in cycles; 0 means 2^RWID; sampled at grant
rngClr  output  1  synchronous clear to the RNG array (restart at sequence index 0)
rngEn  output  1  enable to the RNG array
gnt  output  NREQ  one-hot grant, held for the whole epoch
streamValid  output  1  rngSeq at the array output is valid for the granted requester
done  output  NREQ  one-cycle pulse on the granted requester's bit at epoch end
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, rrPtr=0, lenCnt=0, valid shift register cleared, all outputs 0.
- Reset asserted mid-epoch aborts immediately. No done is issued. After release the scheduler rearbitrates from rrPtr=0.
- FSM states IDLE → CLR → RUN → DRAIN → DONE → IDLE.
- IDLE:
  - If req≠0, round-robin grant. Search starts at rrPtr; the lowest index at or after rrPtr wins, with wrap-around.
  - gnt is registered and goes high on entry to CLR.
  - rrPtr ← winner+1 mod NREQ.
  - lenCnt ← cfgLen, or 2^RWID when cfgLen=0.
- CLR: rngClr=1 and rngEn=0 for exactly 1 cycle → RUN.
- RUN:
  - rngEn=1 and lenCnt decrements each cycle.
  - When lenCnt reaches 1 (last enabled cycle) → DRAIN.
  - rngEn is high for exactly len cycles.
- DRAIN: rngEn=0; stay LAT cycles (internal counter) → DONE.
- DONE: done[granted]=1 for 1 cycle; gnt drops with the transition to IDLE.
- streamValid = rngEn delayed by LAT cycles through a shift register. It is high for exactly len consecutive cycles, the last of which is the final DRAIN cycle.
- gnt is stable and one-hot from CLR through DONE inclusive; it is 0 in IDLE.
- A request deasserted mid-epoch does not abort: the epoch completes and done still pulses.
- New requests arriving mid-epoch wait. Minimum gap between epochs is 1 IDLE cycle.
- Simultaneous requests: resolved only by round-robin; no starvation. Worst-case wait is (NREQ−1) epochs.
- cfgLen changes after grant are ignored.
- Epoch length in cycles = 1 (CLR) + len + LAT + 1 (DONE), followed by 1 cycle in IDLE.
- Counter widths: lenCnt is RWID+1 bits to hold 2^RWID; the LAT counter is clog2(LAT+1) bits.

Decomposition:
- Package rng_sched_pkg: state enum (IDLE, CLR, RUN, DRAIN, DONE), LAT default constant, helper for effective length (0 → 2^RWID).
- Sub-module rr_arbiter: combinational round-robin pick from req and rrPtr; outputs one-hot winner and winner index.
- The FSM, counters and valid shift register stay in rng_epoch_scheduler.

Test Plan:
- Single request: req=0001, cfgLen=4.
  - rngClr at cycle t+1; rngEn t+2..t+5.
  - streamValid t+4..t+7; done=0001 at t+8; gnt=0001 t+1..t+8.
- Full length: cfgLen=0, RWID=8 → rngEn high exactly 256 cycles; streamValid 256 cycles; one done pulse.
- Round-robin: req=1111 held, cfgLen=2 → grant order 0001, 0010, 0100, 1000, 0001; each epoch has one done pulse on its grant bit.
- Deassert and config change mid-epoch: req[2] drops during RUN and cfgLen changes during RUN → epoch still runs the original len; done=0100 pulses; next grant goes to the next requester.
- Async reset mid-epoch: rst pulsed during RUN with req=0010.
  - All outputs go to 0 immediately, with no done.
  - After release with req=1010, the first gnt is 0010 (rrPtr=0).
- Back-to-back: req[1] held continuously alone → consecutive epochs separated by exactly 1 IDLE cycle; rngClr precedes every epoch.
